// File: rtl/rs_slot_alloc.sv
// Dual-grant slot allocator for a reservation station: grants the lowest and
// highest free slots each cycle and tracks occupancy, free count and misuse.
module rs_slot_alloc #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned IDX     = 5,
  parameter int unsigned CNT     = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         alloc_req,
  input  logic [ENTRIES-1:0] free_en,
  input  logic               flush,
  output logic [1:0]         alloc_gnt,
  output logic [IDX-1:0]     alloc_idx0,
  output logic [IDX-1:0]     alloc_idx1,
  output logic [ENTRIES-1:0] busy,
  output logic [CNT-1:0]     free_count,
  output logic               full,
  output logic               free_err
);

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [CNT-1:0]     free_count_q, free_count_d;
  logic               full_q, full_d;
  logic               free_err_q, free_err_d;

  logic [ENTRIES-1:0] free_vec;
  logic [IDX-1:0]     idx_lo, idx_hi;
  logic [1:0]         gnt;

  // Low/high priority encoders; both fall back to 0 when nothing is free.
  always_comb begin
    free_vec = ~busy_q;
    idx_lo   = '0;
    idx_hi   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (free_vec[ENTRIES-1-i]) idx_lo = IDX'(ENTRIES-1-i);
      if (free_vec[i])           idx_hi = IDX'(i);
    end
  end

  // Grant 1 needs a second distinct free slot, so one free slot gives grant 0 only.
  always_comb begin
    gnt = '0;
    if (!flush && alloc_req[0] && (free_count_q != '0)) begin
      gnt[0] = 1'b1;
      if (alloc_req[1] && (free_count_q >= CNT'(2))) gnt[1] = 1'b1;
    end
  end

  always_comb begin
    busy_d     = '0;
    free_err_d = free_err_q;
    if (!flush) begin
      busy_d = busy_q & ~free_en;
      if (gnt[0]) busy_d[idx_lo] = 1'b1;
      if (gnt[1]) busy_d[idx_hi] = 1'b1;
      free_err_d = free_err_q | (|(free_en & ~busy_q));
    end
  end

  always_comb begin
    free_count_d = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      free_count_d = free_count_d + CNT'(~busy_d[i]);
    end
    full_d = (free_count_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q       <= '0;
      free_count_q <= CNT'(ENTRIES);
      full_q       <= 1'b0;
      free_err_q   <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      free_count_q <= free_count_d;
      full_q       <= full_d;
      free_err_q   <= free_err_d;
    end
  end

  assign alloc_gnt  = gnt;
  assign alloc_idx0 = idx_lo;
  assign alloc_idx1 = idx_hi;
  assign busy       = busy_q;
  assign free_count = free_count_q;
  assign full       = full_q;
  assign free_err   = free_err_q;

endmodule

// File: tb/tb_rs_slot_alloc.sv
// Directed self-checking bench for rs_slot_alloc.
module tb_rs_slot_alloc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  alloc_req = '0;
  logic [31:0] free_en = '0;
  logic        flush = 1'b0;
  logic [1:0]  alloc_gnt;
  logic [4:0]  alloc_idx0, alloc_idx1;
  logic [31:0] busy;
  logic [5:0]  free_count;
  logic        full, free_err;

  int checks = 0;
  int failures = 0;

  rs_slot_alloc #(.ENTRIES(32), .IDX(5), .CNT(6)) dut (
    .clock(clock), .reset(reset), .alloc_req(alloc_req), .free_en(free_en),
    .flush(flush), .alloc_gnt(alloc_gnt), .alloc_idx0(alloc_idx0),
    .alloc_idx1(alloc_idx1), .busy(busy), .free_count(free_count),
    .full(full), .free_err(free_err)
  );

  always #5 clock = ~clock;

  // Inputs change at negedge; registered results are sampled at the next negedge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    alloc_req = '0; free_en = '0; flush = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
  endtask

  task automatic fill_all();
    alloc_req = 2'b11; free_en = '0; flush = 1'b0;
    for (int i = 0; i < 16; i++) step();
    alloc_req = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    alloc_req = 2'b11;
    step(); step(); step();
    #3;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 32'h0) begin failures++; $display("FAIL rst_busy got=%h exp=%h", busy, 32'h0); end
    checks++; if (free_count !== 6'd32) begin failures++; $display("FAIL rst_count got=%0d exp=32", free_count); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
    checks++; if (alloc_idx0 !== 5'd0) begin failures++; $display("FAIL rst_idx0 got=%0d exp=0", alloc_idx0); end
    checks++; if (alloc_idx1 !== 5'd31) begin failures++; $display("FAIL rst_idx1 got=%0d exp=31", alloc_idx1); end
    checks++; if (free_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", free_err); end
    checks++; if (alloc_gnt !== 2'b11) begin failures++; $display("FAIL rst_gnt got=%b exp=11", alloc_gnt); end
    alloc_req = 2'b00;
    #1;
    reset = 1'b1;
    step();
  endtask

  task automatic test_dual_grant();
    do_reset();
    alloc_req = 2'b11;
    #1;
    checks++; if (alloc_gnt !== 2'b11) begin failures++; $display("FAIL dual_gnt got=%b exp=11", alloc_gnt); end
    checks++; if (alloc_idx0 !== 5'd0) begin failures++; $display("FAIL dual_idx0 got=%0d exp=0", alloc_idx0); end
    checks++; if (alloc_idx1 !== 5'd31) begin failures++; $display("FAIL dual_idx1 got=%0d exp=31", alloc_idx1); end
    step();
    alloc_req = 2'b00;
    checks++; if (busy !== 32'h8000_0001) begin failures++; $display("FAIL dual_busy got=%h exp=%h", busy, 32'h8000_0001); end
    checks++; if (free_count !== 6'd30) begin failures++; $display("FAIL dual_count got=%0d exp=30", free_count); end
    alloc_req = 2'b10;
    #1;
    checks++; if (alloc_gnt !== 2'b00) begin failures++; $display("FAIL req10_gnt got=%b exp=00", alloc_gnt); end
    alloc_req = 2'b01;
    #1;
    checks++; if (alloc_gnt !== 2'b01) begin failures++; $display("FAIL req01_gnt got=%b exp=01", alloc_gnt); end
    checks++; if (alloc_idx0 !== 5'd1) begin failures++; $display("FAIL req01_idx0 got=%0d exp=1", alloc_idx0); end
    checks++; if (alloc_idx1 !== 5'd30) begin failures++; $display("FAIL req01_idx1 got=%0d exp=30", alloc_idx1); end
    step();
    alloc_req = 2'b00;
    checks++; if (busy !== 32'h8000_0003) begin failures++; $display("FAIL req01_busy got=%h exp=%h", busy, 32'h8000_0003); end
  endtask

  task automatic test_last_slot();
    do_reset();
    fill_all();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    free_en = 32'h0000_0001;
    step();
    free_en = '0;
    checks++; if (busy !== 32'hffff_fffe) begin failures++; $display("FAIL one_busy got=%h exp=%h", busy, 32'hffff_fffe); end
    checks++; if (free_count !== 6'd1) begin failures++; $display("FAIL one_count got=%0d exp=1", free_count); end
    alloc_req = 2'b11;
    #1;
    checks++; if (alloc_gnt !== 2'b01) begin failures++; $display("FAIL one_gnt got=%b exp=01", alloc_gnt); end
    checks++; if (alloc_idx0 !== 5'd0) begin failures++; $display("FAIL one_idx0 got=%0d exp=0", alloc_idx0); end
    step();
    alloc_req = 2'b00;
    checks++; if (busy !== 32'hffff_ffff) begin failures++; $display("FAIL full_busy got=%h exp=%h", busy, 32'hffff_ffff); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full); end
    checks++; if (free_count !== 6'd0) begin failures++; $display("FAIL full_count got=%0d exp=0", free_count); end
    alloc_req = 2'b01;
    #1;
    checks++; if (alloc_gnt !== 2'b00) begin failures++; $display("FAIL full_gnt got=%b exp=00", alloc_gnt); end
    alloc_req = 2'b00;
  endtask

  task automatic test_back_to_back();
    alloc_req = 2'b11; free_en = 32'h0f00_0000;
    #1;
    checks++; if (alloc_gnt !== 2'b00) begin failures++; $display("FAIL b2b_gnt got=%b exp=00", alloc_gnt); end
    step();
    free_en = '0;
    #1;
    checks++; if (free_count !== 6'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", free_count); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", full); end
    checks++; if (alloc_gnt !== 2'b11) begin failures++; $display("FAIL b2b_gnt2 got=%b exp=11", alloc_gnt); end
    checks++; if (alloc_idx0 !== 5'd24) begin failures++; $display("FAIL b2b_idx0 got=%0d exp=24", alloc_idx0); end
    checks++; if (alloc_idx1 !== 5'd27) begin failures++; $display("FAIL b2b_idx1 got=%0d exp=27", alloc_idx1); end
    step();
    alloc_req = 2'b00;
    checks++; if (busy !== 32'hf9ff_ffff) begin failures++; $display("FAIL b2b_busy got=%h exp=%h", busy, 32'hf9ff_ffff); end
    checks++; if (free_count !== 6'd2) begin failures++; $display("FAIL b2b_count2 got=%0d exp=2", free_count); end
  endtask

  task automatic test_free_err();
    do_reset();
    fill_all();
    free_en = ~32'h0000_00f0;
    step();
    checks++; if (busy !== 32'h0000_00f0) begin failures++; $display("FAIL ferr_setup got=%h exp=%h", busy, 32'h0000_00f0); end
    checks++; if (free_err !== 1'b0) begin failures++; $display("FAIL ferr_clean got=%b exp=0", free_err); end
    free_en = 32'h0000_0101;
    step();
    free_en = '0;
    checks++; if (busy !== 32'h0000_00f0) begin failures++; $display("FAIL ferr_busy got=%h exp=%h", busy, 32'h0000_00f0); end
    checks++; if (free_err !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", free_err); end
    checks++; if (free_count !== 6'd28) begin failures++; $display("FAIL ferr_count got=%0d exp=28", free_count); end
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (free_err !== 1'b1) begin failures++; $display("FAIL ferr_sticky got=%b exp=1", free_err); end
    do_reset();
    checks++; if (free_err !== 1'b0) begin failures++; $display("FAIL ferr_reset got=%b exp=0", free_err); end
  endtask

  task automatic test_flush();
    do_reset();
    fill_all();
    free_en = ~32'h0f00_00f0;
    step();
    free_en = '0;
    checks++; if (busy !== 32'h0f00_00f0) begin failures++; $display("FAIL fl_setup got=%h exp=%h", busy, 32'h0f00_00f0); end
    flush = 1'b1; alloc_req = 2'b11; free_en = 32'h0000_0001;
    #1;
    checks++; if (alloc_gnt !== 2'b00) begin failures++; $display("FAIL fl_gnt got=%b exp=00", alloc_gnt); end
    step();
    flush = 1'b0; alloc_req = 2'b00; free_en = '0;
    checks++; if (busy !== 32'h0) begin failures++; $display("FAIL fl_busy got=%h exp=%h", busy, 32'h0); end
    checks++; if (free_count !== 6'd32) begin failures++; $display("FAIL fl_count got=%0d exp=32", free_count); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL fl_full got=%b exp=0", full); end
    checks++; if (free_err !== 1'b0) begin failures++; $display("FAIL fl_err got=%b exp=0", free_err); end
  endtask

  initial begin
    test_reset();
    test_dual_grant();
    test_last_slot();
    test_back_to_back();
    test_free_err();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_slot_alloc.md
# rs_slot_alloc

Dual-grant slot allocator for a 32-entry reservation station. Tracks a registered busy vector and grants up to two free slots per cycle to in-order dispatch: the lowest free index to slot request 0 and the highest free index to slot request 1, using a high/low priority encoder over the free vector. Sits between the dispatch stage and the RS entry array. Completing or issuing entries return slots through a multi-hot free vector. A flush clears all slots.

## Interface
- ENTRIES, 32, number of RS slots
- IDX, 5, slot index width (log2 ENTRIES)
- CNT, 6, free-count width (holds 0..ENTRIES)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; reset==0 forces reset state immediately
- alloc_req  in  2  in-order requests; bit0 = first instruction, bit1 = second; bit1 without bit0 is ignored
- free_en  in  ENTRIES  multi-hot slots released this cycle
- flush  in  1  squash; clears every slot at next edge
- alloc_gnt  out  2  combinational grants, same cycle as request
- alloc_idx0  out  IDX  slot for grant 0 (lowest free index)
- alloc_idx1  out  IDX  slot for grant 1 (highest free index)
- busy  out  ENTRIES  registered occupancy vector
- free_count  out  CNT  registered popcount of ~busy
- full  out  1  registered, free_count==0
- free_err  out  1  sticky; set when free_en hits a non-busy slot

## Operation
- free = ~busy. enc_low = lowest set bit of free. enc_high = highest set bit of free. valid = |free.
- alloc_idx0 = enc_low. alloc_idx1 = enc_high. Both are 0 when valid==0.
- Grant rules (flush==0):
  - req bit0==0: gnt=00.
  - req==01: gnt=01 if free_count>=1.
  - req==11: gnt=11 if free_count>=2; gnt=01 if free_count==1; else 00.
  - With exactly one free slot, enc_low==enc_high and only grant 0 is given.
- flush==1: gnt forced 00 that cycle.
- Next state, priority high to low:
  - flush: busy_next=0, free_count_next=ENTRIES.
  - Otherwise: busy_next = (busy & ~free_en) | onehot(idx0 if gnt[0]) | onehot(idx1 if gnt[1]).
- Slots freed in cycle N are not grantable until cycle N+1; there is no bypass. Granted slots are never busy, so a free and an allocation never touch the same slot in one cycle.
- free_en bits on non-busy slots change nothing in busy. They set free_err, which holds until reset. Under flush, free_en is ignored and free_err is not updated.
- free_count_next = popcount(~busy_next), or an equivalent incremental update. full_next = (free_count_next==0).

## Timing
- Reset values: busy=0, free_count=32, full=0, free_err=0. Resulting combinational outputs: idx0=0, idx1=31, gnt follows alloc_req.
- Grant-to-occupancy latency: 1 cycle. A slot granted at posedge-N setup appears in busy after edge N.
- Free-to-available latency: 1 cycle.
- alloc_gnt and alloc_idx0/1 are combinational from busy, alloc_req and flush. They must be stable before the posedge; dispatch samples them at the same edge.
- Reset asserted mid-operation clears all state asynchronously, including pending grants. The first edge after reset deassertion behaves as a normal cycle.

## Test plan
- Reset pulse mid-cycle: busy=0, free_count=32, full=0, idx0=0, idx1=31, free_err=0, all without waiting for a clock edge.
- After reset, alloc_req=11 for one cycle: gnt=11, idx0=0, idx1=31. Next cycle busy=32'h8000_0001, free_count=30.
- busy=32'hffff_fffe, alloc_req=11: gnt=01, idx0=0. Next cycle busy=32'hffff_ffff, full=1, free_count=0. Then alloc_req=01 gives gnt=00.
- Full, free_en=32'h0f00_0000 with alloc_req=11 in the same cycle: gnt=00. Next cycle free_count=4; alloc_req=11 gives gnt=11, idx0=24, idx1=27.
- busy=32'h0000_00f0, free_en=32'h0000_0101: busy becomes 32'h0000_00f0 (unchanged) and free_err=1. free_err stays 1 through later cycles until reset.
- busy=32'h0f00_00f0, flush=1, alloc_req=11: gnt=00. Next cycle busy=0, free_count=32, full=0.
